// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field layout, result class encodings and classifier.
// Pure combinational helpers; no state and no flow control.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_INF    = 3'd2,
    CLS_NAN    = 3'd3,
    CLS_NORMAL = 3'd4
  } fp_cls_e;

  // Sign bit is deliberately ignored: class depends on exponent and mantissa only.
  function automatic fp_cls_e fp_classify(input logic [EXP_W+MAN_W:0] z);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    fp_cls_e          c;
    e = z[MAN_W +: EXP_W];
    m = z[MAN_W-1:0];
    if (e == '0)
      c = (m == '0) ? CLS_ZERO : CLS_DENORM;
    else if (e == EXP_MAX)
      c = (m == '0) ? CLS_INF : CLS_NAN;
    else
      c = CLS_NORMAL;
    return c;
  endfunction

endpackage

// File: rtl/fpmul_result_monitor_if.sv
// Operand-valid / FP_Z stream into the result monitor and its classified output.
// Valid-only stream: no ready, the monitor never stalls the multiplier.
interface fpmul_result_monitor_if #(
  parameter int NB = 32
);
  logic          in_valid;
  logic [NB-1:0] fp_z;
  logic          out_valid;
  logic [NB-1:0] out_data;
  logic [2:0]    out_class;

  modport master (
    output in_valid, fp_z,
    input  out_valid, out_data, out_class
  );

  modport slave (
    input  in_valid, fp_z,
    output out_valid, out_data, out_class
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear+inc in one cycle yields 1.
// Latency 1 cycle; no backpressure.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] q
);

  logic [CW-1:0] q_q;
  logic [CW-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = CW'(inc);
    else if (inc && (q_q != '1))
      q_d = q_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/fpmul_result_monitor.sv
// Classifies each FPmul result, keeps saturating class counters, sign-error count and first-NaN index.
// Latency LAT+1 from in_valid to out_valid; no backpressure, the delay line shifts every cycle.
module fpmul_result_monitor
  import fp_pkg::*;
#(
  parameter int NB           = 32,
  parameter int LAT          = 4,
  parameter int CW           = 16,
  parameter int SQUARE_CHECK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  fpmul_result_monitor_if.slave bus,
  input  logic                  clear,
  output logic [CW-1:0]         cnt_total,
  output logic [CW-1:0]         cnt_zero,
  output logic [CW-1:0]         cnt_denorm,
  output logic [CW-1:0]         cnt_inf,
  output logic [CW-1:0]         cnt_nan,
  output logic [CW-1:0]         cnt_normal,
  output logic [CW-1:0]         cnt_sign_err,
  output logic                  nan_seen,
  output logic [CW-1:0]         first_nan_idx
);

  logic [LAT-1:0] dl_q;
  logic           v_al;
  fp_cls_e        cls;
  logic           sign_err;
  logic           nan_hit;

  logic           out_valid_q;
  logic [NB-1:0]  out_data_q;
  fp_cls_e        out_class_q;
  logic           nan_seen_q, nan_seen_d;
  logic [CW-1:0]  first_nan_idx_q, first_nan_idx_d;

  // Oldest tap lines up with the FP_Z produced for that operand pair.
  always_ff @(posedge clk) begin
    if (rst) dl_q <= '0;
    else     dl_q <= LAT'({dl_q, bus.in_valid});
  end

  assign v_al     = dl_q[LAT-1];
  assign cls      = fp_classify(bus.fp_z);
  assign sign_err = (SQUARE_CHECK != 0) && (cls != CLS_NAN) && bus.fp_z[NB-1];
  assign nan_hit  = v_al && (cls == CLS_NAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_class_q <= CLS_ZERO;
    end else begin
      out_valid_q <= v_al;
      if (v_al) begin
        out_data_q  <= bus.fp_z;
        out_class_q <= cls;
      end
    end
  end

  // A NaN arriving with clear is the first sample of the new window, index 0.
  always_comb begin
    nan_seen_d      = nan_seen_q;
    first_nan_idx_d = first_nan_idx_q;
    if (clear) begin
      nan_seen_d      = 1'b0;
      first_nan_idx_d = '0;
    end
    if (nan_hit && !nan_seen_d) begin
      nan_seen_d      = 1'b1;
      first_nan_idx_d = clear ? '0 : cnt_total;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nan_seen_q      <= 1'b0;
      first_nan_idx_q <= '0;
    end else begin
      nan_seen_q      <= nan_seen_d;
      first_nan_idx_q <= first_nan_idx_d;
    end
  end

  sat_counter #(.CW(CW)) u_cnt_total (
    .clk(clk), .rst(rst), .clr(clear), .inc(v_al), .q(cnt_total)
  );

  sat_counter #(.CW(CW)) u_cnt_sign (
    .clk(clk), .rst(rst), .clr(clear), .inc(v_al && sign_err), .q(cnt_sign_err)
  );

  logic [CW-1:0] cls_cnt [5];

  for (genvar c = 0; c < 5; c++) begin : g_cls_cnt
    sat_counter #(.CW(CW)) u_cnt (
      .clk(clk),
      .rst(rst),
      .clr(clear),
      .inc(v_al && (cls == fp_cls_e'(3'(c)))),
      .q  (cls_cnt[c])
    );
  end

  assign cnt_zero      = cls_cnt[CLS_ZERO];
  assign cnt_denorm    = cls_cnt[CLS_DENORM];
  assign cnt_inf       = cls_cnt[CLS_INF];
  assign cnt_nan       = cls_cnt[CLS_NAN];
  assign cnt_normal    = cls_cnt[CLS_NORMAL];

  assign nan_seen      = nan_seen_q;
  assign first_nan_idx = first_nan_idx_q;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_class = out_class_q;

endmodule
